// File: rtl/diff_histogram_pkg.sv
// Shared definitions for the frame-difference histogram block.
// Contents: bus geometry, chip-enable codes, CTRL/STATUS field positions,
// FSM state type and a chip-enable decode helper.
package diff_histogram_pkg;

   localparam int unsigned C_SLV_DWIDTH = 32;
   localparam int unsigned C_NUM_REG    = 4;
   localparam int unsigned C_BINS       = 64;
   localparam int unsigned C_BIN_AW     = 6;

   // One-hot chip enables, MSB is register offset +0x0
   localparam logic [C_NUM_REG-1:0] CE_SAMPLE = 4'b1000;
   localparam logic [C_NUM_REG-1:0] CE_CTRL   = 4'b0100;
   localparam logic [C_NUM_REG-1:0] CE_BIN    = 4'b0010;
   localparam logic [C_NUM_REG-1:0] CE_STATUS = 4'b0001;

   // CTRL / STATUS field positions
   localparam int unsigned CTRL_SEL_LSB   = 0;
   localparam int unsigned CTRL_THR_LSB   = 8;
   localparam int unsigned CTRL_CLR_BIT   = 16;
   localparam int unsigned STAT_BUSY_BIT  = 31;

   typedef enum logic [1:0] {StIdle, StClear, StRd1, StRd2} state_e;

   // True when more than one chip enable is active across both CE vectors
   function automatic logic ce_is_multi(input logic [C_NUM_REG-1:0] rd,
                                        input logic [C_NUM_REG-1:0] wr);
      logic rd_m;
      logic wr_m;
      rd_m = (rd & (rd - 4'd1)) != 4'd0;
      wr_m = (wr & (wr - 4'd1)) != 4'd0;
      return rd_m | wr_m | ((|rd) & (|wr));
   endfunction

endpackage

// File: rtl/diff_histogram_if.sv
// IPIF-style slave bus bundle for diff_histogram.
// master: drives Bus2IP_Data/BE/RdCE/WrCE, receives IP2Bus_Data/RdAck/WrAck/Error.
// slave : the reverse.
interface diff_histogram_if;
   import diff_histogram_pkg::*;

   logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data;
   logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE;
   logic [C_NUM_REG-1:0]      Bus2IP_RdCE;
   logic [C_NUM_REG-1:0]      Bus2IP_WrCE;
   logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data;
   logic                      IP2Bus_RdAck;
   logic                      IP2Bus_WrAck;
   logic                      IP2Bus_Error;

   modport master (
      output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
      input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
   );

   modport slave (
      input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
      output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
   );

endinterface

// File: rtl/diff_histogram_hist_ram.sv
// Histogram bin storage: 2**C_AW x C_CNT_WIDTH, one synchronous read port and one
// write port, no reset (contents are zeroed by the owner's clear sweep).
// A read and write to the same address in one cycle returns the old contents.
// Ports: i_clk; i_rd_addr -> o_rd_data (1-cycle latency); i_we/i_wr_addr/i_wr_data.
module hist_ram #(
   parameter int unsigned C_CNT_WIDTH = 16,
   parameter int unsigned C_AW        = 6
) (
   input  logic                   i_clk,
   input  logic [C_AW-1:0]        i_rd_addr,
   output logic [C_CNT_WIDTH-1:0] o_rd_data,
   input  logic                   i_we,
   input  logic [C_AW-1:0]        i_wr_addr,
   input  logic [C_CNT_WIDTH-1:0] i_wr_data
);

   logic [C_CNT_WIDTH-1:0] r_mem [2**C_AW];
   logic [C_CNT_WIDTH-1:0] r_rd_data;

   always_ff @(posedge i_clk) begin
      r_rd_data <= r_mem[i_rd_addr];
      if (i_we) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/diff_histogram.sv
// 64-bin histogram of 6-bit frame-difference samples with total and motion counters.
// Ports: Bus2IP_Clk, Bus2IP_Reset (async, active-high), io_bus (slave modport).
// Registers: +0x0 SAMPLE (W), +0x4 CTRL (R/W), +0x8 BIN (R), +0xC STATUS (R).
// Sample writes go through a 2-stage read-modify-write on hist_ram with a bypass of
// the most recent RAM write so consecutive same-bin updates never lose a count.
module diff_histogram
   import diff_histogram_pkg::*;
#(
   parameter int unsigned C_CNT_WIDTH = 16
) (
   input logic                Bus2IP_Clk,
   input logic                Bus2IP_Reset,
   diff_histogram_if.slave    io_bus
);

   typedef logic [C_CNT_WIDTH-1:0] cnt_t;
   localparam cnt_t C_CNT_ONE = cnt_t'(1);

   function automatic cnt_t sat_inc(input cnt_t v);
      return (&v) ? v : v + C_CNT_ONE;
   endfunction

   state_e                r_state;
   logic [C_BIN_AW-1:0]   r_clr_addr;
   logic [C_BIN_AW-1:0]   r_bin_sel;
   logic [C_BIN_AW-1:0]   r_thresh;
   cnt_t                  r_total;
   cnt_t                  r_above;
   logic                  r_ack_blk;
   logic                  r_s2_valid;
   logic [C_BIN_AW-1:0]   r_s2_addr;
   logic                  r_wb_valid;
   logic [C_BIN_AW-1:0]   r_wb_addr;
   cnt_t                  r_wb_data;

   logic [C_NUM_REG-1:0]  w_rdce;
   logic [C_NUM_REG-1:0]  w_wrce;
   logic                  w_multi;
   logic                  w_idle;
   logic                  w_busy;
   logic                  w_wr_sample, w_wr_ctrl, w_wr_bad;
   logic                  w_rd_ctrl, w_rd_bin, w_rd_status;
   logic                  w_sample_go, w_accept, w_clr_go;
   logic                  w_hazard, w_bin_start, w_bin_done;
   logic                  w_rd_ack, w_wr_ack, w_err;
   logic [C_SLV_DWIDTH-1:0] w_rdata;
   logic [C_BIN_AW-1:0]   w_value;
   logic [C_BIN_AW-1:0]   w_rd_addr;
   logic                  w_we;
   logic [C_BIN_AW-1:0]   w_wr_addr;
   cnt_t                  w_wr_data;
   cnt_t                  w_ram_rdata;
   cnt_t                  w_base;
   logic                  w_unused;

   // The cycle after any ack ignores CEs so each CE assertion is acked once
   assign w_rdce  = r_ack_blk ? '0 : io_bus.Bus2IP_RdCE;
   assign w_wrce  = r_ack_blk ? '0 : io_bus.Bus2IP_WrCE;
   assign w_multi = ce_is_multi(w_rdce, w_wrce);
   assign w_idle  = (r_state == StIdle);
   assign w_busy  = (r_state == StClear);
   assign w_value = io_bus.Bus2IP_Data[C_BIN_AW-1:0];

   assign w_wr_sample = !w_multi && (w_wrce == CE_SAMPLE);
   assign w_wr_ctrl   = !w_multi && (w_wrce == CE_CTRL);
   assign w_wr_bad    = !w_multi && ((w_wrce == CE_BIN) || (w_wrce == CE_STATUS));
   assign w_rd_ctrl   = !w_multi && (w_rdce == CE_CTRL);
   assign w_rd_bin    = !w_multi && (w_rdce == CE_BIN);
   assign w_rd_status = !w_multi && (w_rdce == CE_STATUS);

   assign w_sample_go = w_wr_sample && w_idle;
   assign w_accept    = w_sample_go && io_bus.Bus2IP_BE[0];
   assign w_clr_go    = w_wr_ctrl && io_bus.Bus2IP_BE[2] && io_bus.Bus2IP_Data[CTRL_CLR_BIT]
                        && w_idle;
   // Hold a BIN read while stage 2 still owes a write to the selected bin
   assign w_hazard    = r_s2_valid && (r_s2_addr == r_bin_sel);
   assign w_bin_start = w_rd_bin && w_idle && !w_hazard;
   assign w_bin_done  = w_rd_bin && (r_state == StRd2);

   // Acks are combinational; reset forces every output low immediately
   assign w_wr_ack = !Bus2IP_Reset &&
                     ((w_multi && (|w_wrce)) || w_sample_go || w_wr_ctrl || w_wr_bad);
   assign w_rd_ack = !Bus2IP_Reset &&
                     ((w_multi && (|w_rdce)) || w_rd_ctrl || w_rd_status || w_bin_done);
   assign w_err    = !Bus2IP_Reset && (w_multi || w_wr_bad);

   always_comb begin
      w_rdata = '0;
      if (w_rd_ack && !w_multi) begin
         if (w_rd_ctrl) begin
            w_rdata = {16'(r_above), 2'b00, r_thresh, 2'b00, r_bin_sel};
         end else if (w_rd_status) begin
            w_rdata = {w_busy, 15'd0, 16'(r_total)};
         end else begin
            w_rdata = 32'(w_ram_rdata);
         end
      end
   end

   assign io_bus.IP2Bus_Data  = w_rdata;
   assign io_bus.IP2Bus_RdAck = w_rd_ack;
   assign io_bus.IP2Bus_WrAck = w_wr_ack;
   assign io_bus.IP2Bus_Error = w_err;

   // RAM port muxing: clear sweep owns the write port while busy
   assign w_rd_addr = (r_state == StRd1) ? r_bin_sel : w_value;
   assign w_base    = (r_wb_valid && (r_wb_addr == r_s2_addr)) ? r_wb_data : w_ram_rdata;
   assign w_we      = w_busy || r_s2_valid;
   assign w_wr_addr = w_busy ? r_clr_addr : r_s2_addr;
   assign w_wr_data = w_busy ? '0 : sat_inc(w_base);

   hist_ram #(
      .C_CNT_WIDTH (C_CNT_WIDTH),
      .C_AW        (C_BIN_AW)
   ) u_ram (
      .i_clk     (Bus2IP_Clk),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_ram_rdata),
      .i_we      (w_we),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (w_wr_data)
   );

   always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) begin
         r_state    <= StClear;
         r_clr_addr <= '0;
      end else begin
         case (r_state)
            StClear: begin
               r_clr_addr <= r_clr_addr + C_BIN_AW'(1);
               if (r_clr_addr == C_BIN_AW'(C_BINS - 1)) r_state <= StIdle;
            end
            StIdle: begin
               if (w_clr_go) begin
                  r_state    <= StClear;
                  r_clr_addr <= '0;
               end else if (w_bin_start) begin
                  r_state <= StRd1;
               end
            end
            StRd1:   r_state <= StRd2;
            StRd2:   r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) begin
         r_bin_sel  <= '0;
         r_thresh   <= C_BIN_AW'(C_BINS - 1);
         r_total    <= '0;
         r_above    <= '0;
         r_ack_blk  <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_addr  <= '0;
         r_wb_valid <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_data  <= '0;
      end else begin
         r_ack_blk <= w_rd_ack | w_wr_ack;
         if (w_wr_ctrl) begin
            if (io_bus.Bus2IP_BE[0]) r_bin_sel <= io_bus.Bus2IP_Data[CTRL_SEL_LSB +: C_BIN_AW];
            if (io_bus.Bus2IP_BE[1]) r_thresh  <= io_bus.Bus2IP_Data[CTRL_THR_LSB +: C_BIN_AW];
         end
         if (w_clr_go) begin
            r_total <= '0;
            r_above <= '0;
         end else if (w_accept) begin
            r_total <= sat_inc(r_total);
            if (w_value > r_thresh) r_above <= sat_inc(r_above);
         end
         r_s2_valid <= w_accept;
         r_s2_addr  <= w_value;
         r_wb_valid <= w_we;
         r_wb_addr  <= w_wr_addr;
         r_wb_data  <= w_wr_data;
      end
   end

   assign w_unused = ^{io_bus.Bus2IP_Data[31:17], io_bus.Bus2IP_Data[15:14],
                       io_bus.Bus2IP_Data[7:6], io_bus.Bus2IP_BE[3]};

endmodule

// File: tb/tb_diff_histogram.sv
// Directed bench for diff_histogram: one 16-bit-counter instance for the main register
// behaviour and one 4-bit-counter instance for saturation.
module tb_diff_histogram;
   import diff_histogram_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0]      t_data;
   logic [3:0]       t_be;
   logic [1:0][3:0]  t_rdce;
   logic [1:0][3:0]  t_wrce;
   logic [1:0][31:0] w_rdata;
   logic [1:0]       w_rdack;
   logic [1:0]       w_wrack;
   logic [1:0]       w_err;

   diff_histogram_if bus0 ();
   diff_histogram_if bus1 ();

   assign bus0.Bus2IP_Data = t_data;
   assign bus0.Bus2IP_BE   = t_be;
   assign bus0.Bus2IP_RdCE = t_rdce[0];
   assign bus0.Bus2IP_WrCE = t_wrce[0];
   assign bus1.Bus2IP_Data = t_data;
   assign bus1.Bus2IP_BE   = t_be;
   assign bus1.Bus2IP_RdCE = t_rdce[1];
   assign bus1.Bus2IP_WrCE = t_wrce[1];
   assign w_rdata = {bus1.IP2Bus_Data, bus0.IP2Bus_Data};
   assign w_rdack = {bus1.IP2Bus_RdAck, bus0.IP2Bus_RdAck};
   assign w_wrack = {bus1.IP2Bus_WrAck, bus0.IP2Bus_WrAck};
   assign w_err   = {bus1.IP2Bus_Error, bus0.IP2Bus_Error};

   diff_histogram dut (
      .Bus2IP_Clk   (clk),
      .Bus2IP_Reset (rst),
      .io_bus       (bus0)
   );

   diff_histogram #(
      .C_CNT_WIDTH (4)
   ) dut_s (
      .Bus2IP_Clk   (clk),
      .Bus2IP_Reset (rst),
      .io_bus       (bus1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; holds CE until ack, drops it, then leaves one idle cycle.
   task automatic bus_op(input int u, input logic is_rd, input logic [3:0] ce,
                         input logic [31:0] d, input logic [3:0] be,
                         output int lat, output logic [31:0] rd, output logic err);
      t_data = d;
      t_be   = be;
      if (is_rd) t_rdce[u] = ce;
      else       t_wrce[u] = ce;
      lat = 0;
      rd  = '0;
      err = 1'b0;
      forever begin
         @(negedge clk);
         if (is_rd ? w_rdack[u] : w_wrack[u]) begin
            rd  = w_rdata[u];
            err = w_err[u];
            break;
         end
         lat++;
         if (lat > 300) break;
      end
      @(posedge clk); #1;
      t_rdce[u] = '0;
      t_wrce[u] = '0;
      @(posedge clk); #1;
   endtask

   task automatic do_wr(input int u, input logic [3:0] ce, input logic [31:0] d,
                        input logic [3:0] be, input string tag, input int exp_lat,
                        input logic exp_err);
      int lat;
      logic [31:0] rd;
      logic err;
      bus_op(u, 1'b0, ce, d, be, lat, rd, err);
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ".err"}, 32'(err), 32'(exp_err));
   endtask

   task automatic do_rd(input int u, input logic [3:0] ce, input string tag,
                        input logic [31:0] exp_data, input int exp_lat, input logic exp_err);
      int lat;
      logic [31:0] rd;
      logic err;
      bus_op(u, 1'b1, ce, 32'd0, 4'h0, lat, rd, err);
      check({tag, ".data"}, rd, exp_data);
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ".err"}, 32'(err), 32'(exp_err));
   endtask

   initial begin
      t_data = '0;
      t_be   = '0;
      t_rdce = '0;
      t_wrce = '0;

      // Outputs stay low during reset even with a zero-latency CE present
      repeat (3) @(posedge clk);
      #1;
      t_rdce[0] = CE_CTRL;
      @(negedge clk);
      check("rst_rdack", 32'(w_rdack[0]), 32'd0);
      check("rst_data", w_rdata[0], 32'd0);
      @(posedge clk); #1;
      t_rdce[0] = '0;
      rst = 1'b0;

      // Clear sweep: busy from cycle 0, BIN read issued in cycle 2 acks in cycle 66
      do_rd(0, CE_STATUS, "st_busy", 32'h8000_0000, 0, 1'b0);
      do_rd(0, CE_BIN, "bin0_after_clr", 32'd0, 64, 1'b0);
      check("idle_data", w_rdata[0], 32'd0);
      do_rd(0, CE_STATUS, "st_idle", 32'd0, 0, 1'b0);
      do_rd(0, CE_CTRL, "ctrl_rst", 32'h0000_3F00, 0, 1'b0);
      do_wr(0, CE_CTRL, 32'd31, 4'b0001, "sel31", 0, 1'b0);
      do_rd(0, CE_BIN, "bin31", 32'd0, 2, 1'b0);
      do_wr(0, CE_CTRL, 32'd63, 4'b0001, "sel63", 0, 1'b0);
      do_rd(0, CE_BIN, "bin63", 32'd0, 2, 1'b0);

      // Same-bin updates
      do_wr(0, CE_SAMPLE, 32'd5, 4'hF, "s5a", 0, 1'b0);
      do_wr(0, CE_SAMPLE, 32'd5, 4'hF, "s5b", 0, 1'b0);
      do_wr(0, CE_SAMPLE, 32'd5, 4'hF, "s5c", 0, 1'b0);
      do_wr(0, CE_SAMPLE, 32'd9, 4'hF, "s9", 0, 1'b0);
      do_wr(0, CE_CTRL, 32'd5, 4'b0001, "sel5", 0, 1'b0);
      do_rd(0, CE_BIN, "bin5", 32'd3, 2, 1'b0);
      do_wr(0, CE_CTRL, 32'd9, 4'b0001, "sel9", 0, 1'b0);
      do_rd(0, CE_BIN, "bin9", 32'd1, 2, 1'b0);
      do_rd(0, CE_STATUS, "total4", 32'd4, 0, 1'b0);

      // thresh=10, then clear with a stalled SAMPLE write 3 cycles later
      do_wr(0, CE_CTRL, 32'h0000_0A00, 4'b0010, "thr10", 0, 1'b0);
      do_rd(0, CE_CTRL, "ctrl_thr", 32'h0000_0A09, 0, 1'b0);
      do_wr(0, CE_CTRL, 32'h0001_0000, 4'b0100, "clear", 0, 1'b0);
      @(posedge clk); #1;
      do_wr(0, CE_SAMPLE, 32'd10, 4'hF, "s10_stall", 62, 1'b0);
      do_wr(0, CE_SAMPLE, 32'd11, 4'hF, "s11", 0, 1'b0);
      do_wr(0, CE_SAMPLE, 32'd63, 4'hF, "s63", 0, 1'b0);
      do_rd(0, CE_CTRL, "above2", 32'h0002_0A09, 0, 1'b0);
      do_rd(0, CE_STATUS, "total3", 32'd3, 0, 1'b0);
      // Only byte 0 enabled: thresh must keep 10
      do_wr(0, CE_CTRL, 32'h0000_123F, 4'b0001, "sel63_be", 0, 1'b0);
      do_rd(0, CE_CTRL, "ctrl_be", 32'h0002_0A3F, 0, 1'b0);
      do_rd(0, CE_BIN, "bin63_1", 32'd1, 2, 1'b0);
      do_wr(0, CE_CTRL, 32'd10, 4'b0001, "sel10", 0, 1'b0);
      do_rd(0, CE_BIN, "bin10_1", 32'd1, 2, 1'b0);
      do_wr(0, CE_CTRL, 32'd5, 4'b0001, "sel5b", 0, 1'b0);
      do_rd(0, CE_BIN, "bin5_cleared", 32'd0, 2, 1'b0);

      // Error responses and ignored sample
      do_wr(0, CE_STATUS, 32'hFFFF_FFFF, 4'hF, "wr_status", 0, 1'b1);
      do_rd(0, CE_STATUS, "status_kept", 32'd3, 0, 1'b0);
      do_wr(0, CE_BIN, 32'hFFFF_FFFF, 4'hF, "wr_bin", 0, 1'b1);
      do_rd(0, 4'b1100, "rd_multi", 32'd0, 0, 1'b1);
      do_wr(0, CE_SAMPLE, 32'd10, 4'b1110, "s_be0", 0, 1'b0);
      do_rd(0, CE_STATUS, "total_be0", 32'd3, 0, 1'b0);

      // Saturation on the 4-bit instance
      for (int i = 0; i < 20; i++) do_wr(1, CE_SAMPLE, 32'd7, 4'hF, "sat_wr", 0, 1'b0);
      do_wr(1, CE_CTRL, 32'd7, 4'b0001, "sat_sel7", 0, 1'b0);
      do_rd(1, CE_BIN, "sat_bin7", 32'd15, 2, 1'b0);
      do_rd(1, CE_STATUS, "sat_total", 32'd15, 0, 1'b0);
      do_rd(1, CE_CTRL, "sat_ctrl", 32'h0000_3F07, 0, 1'b0);

      // Reset while a BIN read is in flight: no ack ever appears
      t_rdce[0] = CE_BIN;
      @(negedge clk);
      check("mid_pre_ack", 32'(w_rdack[0]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("mid_rst_ack", 32'(w_rdack[0]), 32'd0);
      @(negedge clk);
      check("mid_rst_ack2", 32'(w_rdack[0]), 32'd0);
      check("mid_rst_data2", w_rdata[0], 32'd0);
      @(posedge clk); #1;
      t_rdce[0] = CE_CTRL;
      @(negedge clk);
      check("mid_rst_ctrl_ack", 32'(w_rdack[0]), 32'd0);
      check("mid_rst_ctrl_data", w_rdata[0], 32'd0);
      @(posedge clk); #1;
      t_rdce[0] = '0;
      rst = 1'b0;
      do_rd(0, CE_STATUS, "post_rst_busy", 32'h8000_0000, 0, 1'b0);
      do_rd(0, CE_CTRL, "post_rst_ctrl", 32'h0000_3F00, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
